cache_flush_sweeper: RTL and testbench



---
 rtl/cache_flush_sweeper.sv | 128 ++++++++++++
 tb/tb_cache_flush_sweeper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_flush_sweeper.sv
// Per-bank tag-store sequencer: invalidates every line after reset, then flushes every line/way on request.
// Define CACHE_FLUSH_PERF_EN to build the saturating flush_cycles counter; otherwise flush_cycles is 0.
module cache_flush_sweeper #(
    parameter int NUM_LINES = 64,
    parameter int NUM_WAYS  = 1,
    parameter int WRITEBACK = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_req_valid,
    output logic                  flush_req_ready,
    output logic                  flush_done,
    input  logic                  pipe_empty,
    input  logic                  stall,
    output logic                  core_req_block,
    output logic                  init,
    output logic                  flush,
    output logic [((NUM_LINES > 1) ? $clog2(NUM_LINES) : 1)-1:0] line_sel,
    output logic [NUM_WAYS-1:0]   way_sel,
    output logic [31:0]           flush_cycles
);

    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);
    localparam logic [NUM_WAYS-1:0] WAY_RST =
        (WRITEBACK != 0) ? NUM_WAYS'(1) : {NUM_WAYS{1'b1}};

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LW-1:0]        r_line;
    logic [LW-1:0]        w_line_nxt;
    logic [NUM_WAYS-1:0]  r_way;
    logic [NUM_WAYS-1:0]  w_way_nxt;
    logic [NUM_WAYS-1:0]  w_way_rot;
    logic                 w_line_last;

    assign w_way_rot   = (r_way << 1) | (r_way >> (NUM_WAYS - 1));
    assign w_line_last = (r_line == LAST_LINE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_line  <= '0;
            r_way   <= WAY_RST;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_way   <= w_way_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_way_nxt   = r_way;
        case (r_state)
            ST_INIT: begin
                w_line_nxt = r_line + 1'b1;
                if (w_line_last) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush_req_valid) begin
                    w_state_nxt = ST_DRAIN;
                    w_line_nxt  = '0;
                    w_way_nxt   = WAY_RST;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                // A stalled op is not consumed: state, line and way all hold.
                if (!stall) begin
                    if (WRITEBACK != 0) begin
                        w_way_nxt = w_way_rot;
                        if (r_way[NUM_WAYS-1]) begin
                            w_line_nxt = r_line + 1'b1;
                            if (w_line_last) w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_line_nxt = r_line + 1'b1;
                        if (w_line_last) w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign init            = (r_state == ST_INIT);
    assign flush           = (r_state == ST_FLUSH);
    assign flush_done      = (r_state == ST_DONE);
    assign flush_req_ready = (r_state == ST_IDLE);
    assign core_req_block  = (r_state != ST_IDLE);
    assign line_sel        = r_line;
    assign way_sel         = r_way;

`ifdef CACHE_FLUSH_PERF_EN
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cycles <= '0;
        end else if (((r_state == ST_DRAIN) || (r_state == ST_FLUSH)) &&
                     (r_flush_cycles != '1)) begin
            r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign flush_cycles = r_flush_cycles;
`else
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_flush_sweeper.sv
// Scoreboard bench: stimulus queues expected tag ops, per-instance monitors pop and compare them.
module tb_cache_flush_sweeper;

    typedef struct packed {
        logic [1:0] kind;   // 0 init, 1 flush, 2 done
        logic [1:0] line;
        logic [3:0] way;
    } ev_t;

`ifdef CACHE_FLUSH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_a = 1'b0, pipe_a = 1'b1, stall_a = 1'b0;
    logic        ready_a, done_a, block_a, init_a, flush_a;
    logic [1:0]  line_a;
    logic [1:0]  way_a;
    logic [31:0] cyc_a;
    logic        valid_b = 1'b0;
    logic        ready_b, done_b, block_b, init_b, flush_b;
    logic [1:0]  line_b;
    logic [3:0]  way_b;
    logic [31:0] cyc_b;

    int checks = 0;
    int errors = 0;
    ev_t qa[$];
    ev_t qb[$];

    always #5 clk = ~clk;

    cache_flush_sweeper #(.NUM_LINES(4), .NUM_WAYS(2), .WRITEBACK(1)) u_a (
        .clk(clk), .reset(reset), .flush_req_valid(valid_a), .flush_req_ready(ready_a),
        .flush_done(done_a), .pipe_empty(pipe_a), .stall(stall_a), .core_req_block(block_a),
        .init(init_a), .flush(flush_a), .line_sel(line_a), .way_sel(way_a), .flush_cycles(cyc_a)
    );

    cache_flush_sweeper #(.NUM_LINES(4), .NUM_WAYS(4), .WRITEBACK(0)) u_b (
        .clk(clk), .reset(reset), .flush_req_valid(valid_b), .flush_req_ready(ready_b),
        .flush_done(done_b), .pipe_empty(1'b1), .stall(1'b0), .core_req_block(block_b),
        .init(init_b), .flush(flush_b), .line_sel(line_b), .way_sel(way_b), .flush_cycles(cyc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_inits_a();
        for (int i = 0; i < 4; i++) qa.push_back('{kind: 2'd0, line: 2'(i), way: 4'd0});
    endtask

    task automatic push_flush_a();
        for (int l = 0; l < 4; l++)
            for (int w = 0; w < 2; w++)
                qa.push_back('{kind: 2'd1, line: 2'(l), way: 4'(1 << w)});
        qa.push_back('{kind: 2'd2, line: 2'd0, way: 4'd0});
    endtask

    task automatic wait_done_a(input int start, output int n);
        n = start;
        while (!done_a && n < 40) begin
            tick();
            n++;
        end
        if (!done_a) begin
            checks++;
            errors++;
            $display("FAIL timeout_done_a actual=none expected=pulse");
        end
    endtask

    // Monitor A: inits carry no way check; a stalled flush is compared but not popped.
    always @(negedge clk) begin
        ev_t obs;
        ev_t exp;
        if (!reset) begin
            if (init_a && flush_a) begin
                checks++;
                errors++;
                $display("FAIL init_flush_overlap actual=1 expected=0");
            end
            if (init_a || flush_a || done_a) begin
                obs.kind = init_a ? 2'd0 : (flush_a ? 2'd1 : 2'd2);
                obs.line = line_a;
                obs.way  = {2'b00, way_a};
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL op_a unexpected actual=k%0d l%0d w%0h expected=none", obs.kind, obs.line, obs.way);
                end else begin
                    exp = qa[0];
                    if (obs.kind != exp.kind ||
                        (obs.kind == 2'd1 && (obs.line != exp.line || obs.way != exp.way)) ||
                        (obs.kind == 2'd0 && obs.line != exp.line)) begin
                        errors++;
                        $display("FAIL op_a actual=k%0d l%0d w%0h expected=k%0d l%0d w%0h",
                                 obs.kind, obs.line, obs.way, exp.kind, exp.line, exp.way);
                    end
                    if (!(flush_a && stall_a)) void'(qa.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t exp;
        if (!reset && (flush_b || done_b)) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL op_b unexpected actual=l%0d w%0h expected=none", line_b, way_b);
            end else begin
                exp = qb.pop_front();
                if ((done_b ? 2'd2 : 2'd1) != exp.kind ||
                    (flush_b && (line_b != exp.line || way_b != exp.way))) begin
                    errors++;
                    $display("FAIL op_b actual=k%0d l%0d w%0h expected=k%0d l%0d w%0h",
                             done_b ? 2 : 1, line_b, way_b, exp.kind, exp.line, exp.way);
                end
            end
        end
    end

    initial begin
        int n;
        push_inits_a();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_flush", {31'd0, flush_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_block", {31'd0, block_a}, 32'd1);
        chk("rst_way", {30'd0, way_a}, 32'd1);
        chk("rst_cycles", cyc_a, 32'd0);
        repeat (4) tick();
        chk("idle_ready", {31'd0, ready_a}, 32'd1);
        chk("idle_block", {31'd0, block_a}, 32'd0);

        // Two identical flushes with two drain cycles each.
        for (int f = 1; f <= 2; f++) begin
            push_flush_a();
            pipe_a  = 1'b0;
            valid_a = 1'b1;
            tick();
            valid_a = 1'b0;
            chk("drain_block", {31'd0, block_a}, 32'd1);
            chk("drain_ready", {31'd0, ready_a}, 32'd0);
            tick();
            pipe_a = 1'b1;
            wait_done_a(2, n);
            chk("flush_len_drain2", n, 32'd11);
            tick();
            chk("back_idle", {31'd0, ready_a}, 32'd1);
            chk("perf_cycles", cyc_a, PERF ? 32'(10 * f) : 32'd0);
        end

        push_flush_a();
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        repeat (4) tick();
        stall_a = 1'b1;
        repeat (3) tick();
        stall_a = 1'b0;
        wait_done_a(8, n);
        chk("flush_len_stall", n, 32'd13);
        tick();
        chk("perf_after_stall", cyc_a, PERF ? 32'd32 : 32'd0);

        for (int i = 0; i < 4; i++) qb.push_back('{kind: 2'd1, line: 2'(i), way: 4'hf});
        qb.push_back('{kind: 2'd2, line: 2'd0, way: 4'd0});
        chk("b_ready", {31'd0, ready_b}, 32'd1);
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        n = 1;
        while (!done_b && n < 40) begin
            tick();
            n++;
        end
        chk("b_flush_len", n, 32'd6);
        tick();

        // Long drain, then reset two ops into the flush.
        push_flush_a();
        pipe_a  = 1'b0;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_no_flush", {31'd0, flush_a}, 32'd0);
            chk("drain_blocked", {31'd0, block_a}, 32'd1);
            if (i == 5) pipe_a = 1'b1;
            tick();
        end
        chk("first_flush", {31'd0, flush_a}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        qa.delete();
        push_inits_a();
        tick();
        reset = 1'b0;
        chk("abort_init", {31'd0, init_a}, 32'd1);
        chk("abort_line", {30'd0, line_a}, 32'd0);
        chk("abort_no_done", {31'd0, done_a}, 32'd0);
        chk("abort_cycles", cyc_a, 32'd0);
        repeat (4) tick();
        chk("abort_idle", {31'd0, ready_a}, 32'd1);
        tick();
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
